// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU among NREQ requesters.
// Define ALU_SCHED_FLAGS_EN to add registered rsp_zero/rsp_neg result flags.
module alu_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int OPW  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*DW-1:0]  req_imm,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [DW-1:0]     alu_imm,
    output logic [OPW-1:0]    alu_control,
    output logic              alu_reset,
    input  logic [DW-1:0]     alu_result,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_data,
`ifdef ALU_SCHED_FLAGS_EN
    output logic              rsp_zero,
    output logic              rsp_neg,
`endif
    input  logic [NREQ-1:0]   rsp_ready
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   rr_ptr, owner, winner;
    logic            grant_found;
    logic [OPW-1:0]  lat_op;
    logic [DW-1:0]   lat_a, lat_b, lat_imm, capture;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int            idx_int;
        logic [PW-1:0] idx;
        grant_found = 1'b0;
        winner      = '0;
        idx_int     = 0;
        idx         = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_int = (int'(rr_ptr) + i) % NREQ;
            idx     = PW'(idx_int);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                winner      = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found)
            req_ready[winner] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP)
            rsp_valid[owner] = 1'b1;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready[owner]) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // MOVE, MOVEI and NOP bypass the ALU result entirely.
    always_comb begin
        capture = alu_result;
        case (int'(lat_op))
            0:       capture = '0;
            5:       capture = lat_a;
            16:      capture = lat_imm;
            default: capture = alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= PW'(NREQ - 1);
            owner     <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_imm   <= '0;
            rsp_data  <= '0;
            alu_reset <= 1'b1;
`ifdef ALU_SCHED_FLAGS_EN
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
`endif
        end else begin
            alu_reset <= (next_state != EXEC);
            if (state == IDLE && grant_found) begin
                lat_op  <= req_op[int'(winner)*OPW +: OPW];
                lat_a   <= req_a[int'(winner)*DW +: DW];
                lat_b   <= req_b[int'(winner)*DW +: DW];
                lat_imm <= req_imm[int'(winner)*DW +: DW];
                owner   <= winner;
                rr_ptr  <= winner;
            end
            if (state == EXEC) begin
                rsp_data <= capture;
`ifdef ALU_SCHED_FLAGS_EN
                rsp_zero <= (capture == '0);
                rsp_neg  <= capture[DW-1];
`endif
            end
        end
    end

    assign alu_a       = lat_a;
    assign alu_b       = lat_b;
    assign alu_imm     = lat_imm;
    assign alu_control = lat_op;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural ALU stand-in.
module tb_alu_sched;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int OPW  = 6;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_op;
    logic [NREQ*DW-1:0]   req_a, req_b, req_imm;
    logic [DW-1:0]        alu_a, alu_b, alu_imm, alu_result;
    logic [OPW-1:0]       alu_control;
    logic                 alu_reset;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic [NREQ-1:0]      rsp_ready;
`ifdef ALU_SCHED_FLAGS_EN
    logic                 rsp_zero, rsp_neg;
`endif

    int total = 0;
    int bad   = 0;

    alu_sched #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
        .alu_control(alu_control), .alu_reset(alu_reset),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
`ifdef ALU_SCHED_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
        .rsp_ready(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(logic rst, logic [5:0] op,
                                              logic [31:0] a, logic [31:0] b,
                                              logic [31:0] imm);
        if (rst) return 32'd0;
        case (op)
            6'd1:         return a + b;
            6'd2, 6'd10:  return a - b;
            6'd12:        return a & b;
            6'd17:        return (imm >= 32) ? 32'd0 : (a << imm);
            6'd18:        return (imm >= 32) ? 32'd0 : (a >> imm);
            6'd20:        return a - imm;
            default:      return a + b;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_reset, alu_control, alu_a, alu_b, alu_imm);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [5:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm);
        req_valid[idx]           = valid;
        req_op[idx*OPW +: OPW]   = op;
        req_a[idx*DW +: DW]      = a;
        req_b[idx*DW +: DW]      = b;
        req_imm[idx*DW +: DW]    = imm;
    endtask

    // Entered and left on a falling edge with the scheduler idle.
    task automatic runOp(input string tag, input int idx, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] exp);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        rsp_ready = '0;
        applyStimulus(idx, 1'b1, op, a, b, imm);
        #1 checkOutput({tag, "_ready"}, 32'(req_ready), 32'(onehot));
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_exec_aluRst"}, 32'(alu_reset), 32'd0);
        checkOutput({tag, "_exec_aluA"}, alu_a, a);
        checkOutput({tag, "_exec_op"}, 32'(alu_control), 32'(op));
        checkOutput({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(onehot));
        checkOutput({tag, "_rsp_data"}, rsp_data, exp);
        checkOutput({tag, "_rsp_aluRst"}, 32'(alu_reset), 32'd1);
`ifdef ALU_SCHED_FLAGS_EN
        checkOutput({tag, "_zero"}, 32'(rsp_zero), 32'(exp == 32'd0));
        checkOutput({tag, "_neg"}, 32'(rsp_neg), 32'(exp[31]));
`endif
        rsp_ready[idx] = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(rsp_valid), 32'd0);
        rsp_ready = '0;
    endtask

    typedef struct {
        int          idx;
        logic [5:0]  op;
        logic [31:0] a, b, imm, exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 6'd1,  32'd5,          32'd7, 32'd0,      32'd12};
        vecs[1] = '{1, 6'd5,  32'hDEADBEEF,   32'd1, 32'd0,      32'hDEADBEEF};
        vecs[2] = '{0, 6'd16, 32'd7,          32'd0, 32'h1234,   32'h1234};
        vecs[3] = '{1, 6'd0,  32'd3,          32'd4, 32'd0,      32'd0};
        vecs[4] = '{0, 6'd17, 32'd1,          32'd0, 32'd4,      32'd16};
        vecs[5] = '{1, 6'd17, 32'd1,          32'd0, 32'd32,     32'd0};
        vecs[6] = '{0, 6'd63, 32'd2,          32'd3, 32'd0,      32'd5};
        vecs[7] = '{1, 6'd2,  32'd3,          32'd5, 32'd0,      32'hFFFFFFFE};
        vecs[8] = '{0, 6'd10, 32'd9,          32'd9, 32'd0,      32'd0};
        vecs[9] = '{1, 6'd18, 32'h80,         32'd0, 32'd4,      32'd8};

        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_imm   = '0;
        rsp_ready = '0;
        #12;
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_data", rsp_data, 32'd0);
        checkOutput("rst_aluRst", 32'(alu_reset), 32'd1);
        checkOutput("rst_aluA", alu_a, 32'd0);
        checkOutput("rst_op", 32'(alu_control), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Alternating requesters leave rr_ptr pointing at requester 1.
        foreach (vecs[k])
            runOp($sformatf("vec%0d", k), vecs[k].idx, vecs[k].op, vecs[k].a,
                  vecs[k].b, vecs[k].imm, vecs[k].exp);

        applyStimulus(0, 1'b1, 6'd20, 32'd100, 32'd0, 32'd1);
        applyStimulus(1, 1'b1, 6'd20, 32'd50,  32'd0, 32'd2);
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 checkOutput($sformatf("rr%0d_grant", k), 32'(req_ready),
                           (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("rr%0d_valid", k), 32'(rsp_valid),
                        (k % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("rr%0d_data", k), rsp_data,
                        (k % 2 == 0) ? 32'd99 : 32'd48);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;

        applyStimulus(1, 1'b1, 6'd12, 32'hF0F0, 32'h0FF0, 32'd0);
        #1 checkOutput("bp_grant", 32'(req_ready), 32'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        applyStimulus(0, 1'b1, 6'd1, 32'd20, 32'd22, 32'd0);
        @(negedge clk);
        checkOutput("bp_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd2);
            checkOutput($sformatf("bp%0d_data", k), rsp_data, 32'h00F0);
            checkOutput($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_req0_grant", 32'(req_ready), 32'd1);
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_req0_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_req0_data", rsp_data, 32'd42);
        @(negedge clk);
        rsp_ready = '0;

        // rr_ptr now favours requester 1; reset must hand priority back to 0.
        applyStimulus(0, 1'b1, 6'd1, 32'd1, 32'd1, 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_aluRst", 32'(alu_reset), 32'd1);
        checkOutput("mid_rst_aluA", alu_a, 32'd0);
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_noRsp", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_data", rsp_data, 32'd0);
        applyStimulus(0, 1'b1, 6'd1, 32'd1, 32'd1, 32'd0);
        applyStimulus(1, 1'b1, 6'd1, 32'd2, 32'd2, 32'd0);
        #1 checkOutput("mid_rst_prio", 32'(req_ready), 32'd1);
        req_valid = '0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
